// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Brief  : Shared constants, FSM state type and parity helper for the
//          rate-1/2, K=4 convolutional encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int K        = 4;
    localparam int M        = 3;
    localparam int TAIL_LEN = 3;
    localparam int CNT_W    = 8;

    localparam logic [K-1:0] G0_DEFAULT = 4'b1011;
    localparam logic [K-1:0] G1_DEFAULT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } conv_state_t;

    function automatic logic parity_bit(input logic [K-1:0] g, input logic [K-1:0] v);
        return ^(g & v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_parity.sv
// ============================================================================
// Module : conv_parity
// Brief  : Combinational code-bit generator; sym = {c0, c1} for {in_bit, state}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_parity
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic         in_bit,
    input  logic [M-1:0] state,
    output logic [1:0]   sym
);

    logic [K-1:0] vec;

    assign vec = {in_bit, state};
    assign sym = {parity_bit(G0, vec), parity_bit(G1, vec)};

endmodule

`default_nettype wire

// File: rtl/conv_encoder.sv
// ============================================================================
// Module : conv_encoder
// Brief  : Framed rate-1/2 convolutional encoder with a one-slot registered
//          output stage. Define CONV_ENC_TAIL_EN for zero-tail termination.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_encoder
    import conv_pkg::*;
#(
    parameter int           FRAME_LEN = 8,
    parameter logic [K-1:0] G0        = G0_DEFAULT,
    parameter logic [K-1:0] G1        = G1_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [1:0]   enc_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [M-1:0] enc_state,
    output logic         busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    conv_state_t      fsm;
    logic [M-1:0]     s;
    logic [CNT_W-1:0] bit_cnt;
    logic             slot_free;
    logic             accept;
    logic             tail_go;
    logic             load;
    logic             enc_bit;
    logic             last_data;
    logic [1:0]       sym;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !rst && (fsm != ST_TAIL) && slot_free;
    assign accept    = in_valid && in_ready;
    assign tail_go   = (fsm == ST_TAIL) && slot_free;
    assign load      = accept || tail_go;
    // Tail insertion feeds zeros through the same parity path.
    assign enc_bit   = accept ? in_bit : 1'b0;
    assign last_data = accept && (bit_cnt == LAST_CNT);
    assign busy      = (fsm != ST_IDLE);
    assign enc_state = s;

    conv_parity #(
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .in_bit (enc_bit),
        .state  (s),
        .sym    (sym)
    );

`ifdef CONV_ENC_TAIL_EN
    localparam logic [1:0] TAIL_LAST = 2'(TAIL_LEN - 1);
    logic [1:0] tail_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ST_IDLE;
            s         <= '0;
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            enc_out   <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                enc_out   <= sym;
                out_valid <= 1'b1;
                s         <= {enc_bit, s[M-1:1]};
                out_last  <= tail_go && (tail_cnt == TAIL_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                bit_cnt <= bit_cnt + 1'b1;
                fsm     <= last_data ? ST_TAIL : ST_DATA;
            end
            // Three zero bits flush the register, so s is back at 000 on exit.
            if (tail_go) begin
                if (tail_cnt == TAIL_LAST) begin
                    fsm      <= ST_IDLE;
                    bit_cnt  <= '0;
                    tail_cnt <= '0;
                end else begin
                    tail_cnt <= tail_cnt + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ST_IDLE;
            s         <= '0;
            bit_cnt   <= '0;
            enc_out   <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                enc_out   <= sym;
                out_valid <= 1'b1;
                // Unterminated frames still start every frame from state 0.
                s         <= last_data ? '0 : {enc_bit, s[M-1:1]};
                out_last  <= last_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                if (last_data) begin
                    fsm     <= ST_IDLE;
                    bit_cnt <= '0;
                end else begin
                    fsm     <= ST_DATA;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire
